// File: rtl/sail_print_pkg.sv
// Shared types, state encoding and ASCII constants for the sail print stream.
// SAIL_PRINT_CHANNEL_TAG_EN selects the channel-tag prefix; the TAG state is
// encoded in both builds so the state width never changes.
package sail_print_pkg;

  typedef logic [7:0] sail_byte_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAG     = 2'd1,
    GRANT   = 2'd2,
    NEWLINE = 2'd3
  } sail_print_state_t;

  localparam sail_byte_t ASCII_NL    = 8'h0A;
  localparam sail_byte_t ASCII_COLON = 8'h3A;

  // Lower-case hex digit for a channel number.
  function automatic sail_byte_t hex_ascii(input logic [3:0] n);
    sail_byte_t r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h57 + {4'h0, n};
    end
    return r;
  endfunction

endpackage

// File: rtl/sail_byte_fifo.sv
// Byte FIFO without bypass: full/empty/count are registered, and the head
// byte reads as zero while the FIFO is empty.
module sail_byte_fifo
  import sail_print_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  sail_byte_t               push_data,
  input  logic                     pop,
  output sail_byte_t               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  sail_byte_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count_next;
  logic            push_ok;
  logic            pop_ok;

  // A push at full is dropped; a pop at full still proceeds.
  always_comb begin
    push_ok    = push & ~full;
    pop_ok     = pop & ~empty;
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + PTR_ONE : wr_ptr;
      rd_ptr <= pop_ok  ? rd_ptr + PTR_ONE : rd_ptr;
      count  <= count_next;
      full   <= (count_next == CNT_FULL);
      empty  <= (count_next == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign pop_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/sail_print_stream.sv
// Multi-channel print stream: round-robin whole-message arbitration into a
// byte FIFO, optional trailing newline per message.
// Optional build macro SAIL_PRINT_CHANNEL_TAG_EN prefixes each message with
// "<hex channel>:".
module sail_print_stream
  import sail_print_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     in_valid,
  output logic [NUM_CH-1:0]     in_ready,
  input  logic [NUM_CH*8-1:0]   in_byte,
  input  logic [NUM_CH-1:0]     in_last,
  input  logic [NUM_CH-1:0]     in_endline,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_byte,
  output logic                  busy
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

  sail_print_state_t state, state_next;
  logic [GW-1:0]     grant, grant_next;
  logic [GW-1:0]     rr, rr_next;
  logic [GW-1:0]     pick;
  logic              pick_valid;
  logic              g_valid, g_last, g_endline;
  sail_byte_t        g_byte;
  logic              push;
  sail_byte_t        push_data;
  logic              full, empty;
  logic [$clog2(DEPTH):0] fifo_count;
  int                idx;
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
  logic              tag_phase, tag_phase_next;
`endif

  // Rotating-priority search starting at the round-robin pointer.
  always_comb begin
    pick       = rr;
    pick_valid = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx        = int'(rr) + i;
      idx        = (idx >= NUM_CH) ? idx - NUM_CH : idx;
      pick       = (!pick_valid && in_valid[idx]) ? GW'(idx) : pick;
      pick_valid = pick_valid | in_valid[idx];
    end
  end

  // Route the granted channel's inputs.
  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_endline = 1'b0;
    g_byte    = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      g_valid   = (grant == GW'(k)) ? in_valid[k]      : g_valid;
      g_last    = (grant == GW'(k)) ? in_last[k]       : g_last;
      g_endline = (grant == GW'(k)) ? in_endline[k]    : g_endline;
      g_byte    = (grant == GW'(k)) ? in_byte[8*k +: 8] : g_byte;
    end
  end

  // Next-state, grant, round-robin pointer and FIFO push selection.
  always_comb begin
    state_next = state;
    grant_next = grant;
    rr_next    = rr;
    push       = 1'b0;
    push_data  = 8'h00;
    in_ready   = '0;
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
    tag_phase_next = tag_phase;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_next = pick;
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
          state_next = TAG;
`else
          state_next = GRANT;
`endif
        end else begin
          state_next = IDLE;
        end
      end
      TAG: begin
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
        if (!full) begin
          push = 1'b1;
          if (!tag_phase) begin
            push_data      = hex_ascii(4'(grant));
            tag_phase_next = 1'b1;
          end else begin
            push_data      = ASCII_COLON;
            tag_phase_next = 1'b0;
            state_next     = GRANT;
          end
        end else begin
          push = 1'b0;
        end
`else
        state_next = IDLE;
`endif
      end
      GRANT: begin
        in_ready = full ? '0 : (NUM_CH'(1) << grant);
        if (g_valid && !full) begin
          push      = 1'b1;
          push_data = g_byte;
          if (g_last) begin
            rr_next    = (grant == LAST_CH) ? '0 : grant + GW'(1);
            state_next = g_endline ? NEWLINE : IDLE;
          end else begin
            state_next = GRANT;
          end
        end else begin
          push = 1'b0;
        end
      end
      NEWLINE: begin
        if (!full) begin
          push       = 1'b1;
          push_data  = ASCII_NL;
          state_next = IDLE;
        end else begin
          state_next = NEWLINE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, grant and round-robin registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      rr    <= '0;
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
      tag_phase <= 1'b0;
`endif
    end else begin
      state <= state_next;
      grant <= grant_next;
      rr    <= rr_next;
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
      tag_phase <= tag_phase_next;
`endif
    end
  end

  sail_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (out_byte),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign out_valid = ~empty;
  assign busy      = (state != IDLE) | (fifo_count != '0);

endmodule

// File: tb/tb_sail_print_stream.sv
// Self-checking bench for sail_print_stream (NUM_CH=2, DEPTH=16).
// Expected bytes go into a scoreboard queue when a message is driven and are
// compared as the sink accepts them.
module tb_sail_print_stream;

  localparam int NUM_CH  = 2;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 300;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_CH-1:0]  in_valid, in_ready, in_last, in_endline;
  logic [NUM_CH*8-1:0] in_byte;
  logic               out_valid, out_ready, busy;
  logic [7:0]         out_byte;

  logic       vld [NUM_CH];
  logic       lst [NUM_CH];
  logic       enl [NUM_CH];
  logic [7:0] byt [NUM_CH];

  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    ch;
    string msg;
    bit    nl;
    string exp;
  } vec_t;

  vec_t vecs [4];

  assign in_valid   = {vld[1], vld[0]};
  assign in_last    = {lst[1], lst[0]};
  assign in_endline = {enl[1], enl[0]};
  assign in_byte    = {byt[1], byt[0]};

  sail_print_stream #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .in_endline (in_endline),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Scoreboard: compare every accepted output byte against the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_byte: got %02h expected none", out_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_byte !== e) begin
          errors++;
          $display("FAIL out_byte: got %02h expected %02h", out_byte, e);
        end
      end
    end
  end

  function automatic logic [7:0] tag_char(input int ch);
    logic [7:0] c;
    c = (ch < 10) ? 8'(8'h30 + ch) : 8'(8'h57 + ch);
    return c;
  endfunction

  task automatic exp_push(input int ch, input string s);
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
    exp_q.push_back(tag_char(ch));
    exp_q.push_back(8'h3A);
`endif
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
  endtask

  task automatic send_msg(input int ch, input string m, input bit nl);
    bit acc;
    int guard;
    for (int i = 0; i < m.len(); i++) begin
      byt[ch] = 8'(m[i]);
      lst[ch] = (i == m.len() - 1);
      enl[ch] = nl;
      vld[ch] = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready[ch];
        @(posedge clk);
        #1;
        guard++;
        if (!acc && guard > TIMEOUT) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: ch %0d byte %0d never accepted", ch, i);
          vld[ch] = 1'b0;
          lst[ch] = 1'b0;
          enl[ch] = 1'b0;
          return;
        end
      end
    end
    vld[ch] = 1'b0;
    lst[ch] = 1'b0;
    enl[ch] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      vld[k] = 1'b0; lst[k] = 1'b0; enl[k] = 1'b0; byt[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int acc_cnt;
    logic [7:0] held;
    logic [7:0] first_exp;

    vecs[0] = '{ch: 1, msg: "x",     nl: 1'b0, exp: "x"};
    vecs[1] = '{ch: 0, msg: "Hello", nl: 1'b1, exp: "Hello\n"};
    vecs[2] = '{ch: 1, msg: "ab",    nl: 1'b1, exp: "ab\n"};
    vecs[3] = '{ch: 0, msg: "z9",    nl: 1'b0, exp: "z9"};

    out_ready = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      vld[k] = 1'b0; lst[k] = 1'b0; enl[k] = 1'b0; byt[k] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {30'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte",  {24'd0, out_byte}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Contention from reset: ch0 first, then ch1 wins the next round.
    exp_push(0, "p0");
    exp_push(1, "r1");
    exp_push(0, "q0");
    fork
      begin
        send_msg(0, "p0", 1'b0);
        send_msg(0, "q0", 1'b0);
      end
      send_msg(1, "r1", 1'b0);
    join
    wait_drain("drain_contention");

    // "hi" with endline: first byte two clocks after in_valid.
    exp_push(0, "hi\n");
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
    first_exp = 8'h30;
`else
    first_exp = 8'h68;
`endif
    fork
      send_msg(0, "hi", 1'b1);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("hi_lat_valid_t1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("hi_lat_valid_t2", {31'd0, out_valid}, 32'd1);
        chk("hi_lat_byte_t2",  {24'd0, out_byte}, {24'd0, first_exp});
      end
    join
    wait_drain("drain_hi");

    // Table of whole messages.
    for (int v = 0; v < 4; v++) begin
      exp_push(vecs[v].ch, vecs[v].exp);
      send_msg(vecs[v].ch, vecs[v].msg, vecs[v].nl);
      wait_drain("drain_table");
    end

    // Single-byte message, no endline: one byte, FSM idle afterwards.
    exp_push(0, "A");
    send_msg(0, "A", 1'b0);
    wait_drain("drain_single");
    @(negedge clk);
    chk("single_idle_ready", {30'd0, in_ready}, 32'd0);
    chk("single_no_valid",   {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: 20 bytes into a 16-byte FIFO with the sink stalled.
    out_ready = 1'b0;
    exp_push(0, "ABCDEFGHIJKLMNOPQRST");
    first_exp = exp_q[0];
    acc_cnt = 0;
    fork
      send_msg(0, "ABCDEFGHIJKLMNOPQRST", 1'b0);
      begin
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (vld[0] && in_ready[0]) acc_cnt++;
        end
`ifdef SAIL_PRINT_CHANNEL_TAG_EN
        chk("stall_accepted", acc_cnt, 32'd14);
`else
        chk("stall_accepted", acc_cnt, 32'd16);
`endif
        chk("stall_in_ready", {30'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        held = out_byte;
        @(negedge clk);
        chk("stall_hold_byte", {24'd0, held}, {24'd0, first_exp});
        chk("stall_hold_now",  {24'd0, out_byte}, {24'd0, first_exp});
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_stall");

    // Reset after 3 of 5 bytes of a ch1 message: everything discarded.
    out_ready = 1'b0;
    acc_cnt = 0;
    vld[1] = 1'b1;
    for (int g = 0; g < 60 && acc_cnt < 3; g++) begin
      byt[1] = 8'h61 + 8'(acc_cnt);
      lst[1] = 1'b0;
      @(negedge clk);
      if (in_ready[1]) acc_cnt++;
      @(posedge clk);
      #1;
    end
    chk("rstmid_accepted", acc_cnt, 32'd3);
    reset = 1'b1;
    vld[1] = 1'b0;
    @(negedge clk);
    chk("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_busy",      {31'd0, busy}, 32'd0);
    chk("rstmid_in_ready",  {30'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rstmid_quiet", {31'd0, out_valid}, 32'd0);

    // Clean traffic after the mid-message reset.
    exp_push(1, "ok\n");
    send_msg(1, "ok", 1'b1);
    wait_drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
